ram_arbiter: RTL

Two-master arbiter for the SoC main RAM port. It shares one single-port RAM (1-cycle registered read latency) between the CPU data path (master 0) and a second bus master such as a DMA or video-fetch engine (master 1). It sits between the masters and the RAM instance, drives the RAM's select, write-enable, mask, address and data inputs, and returns read data to the master that issued the read.

---
 rtl/ram_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-master arbiter for a single-port RAM with 1-cycle read latency.
// Optional burst hold enabled by defining ARB_BURST_EN.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic                    m0_req_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wr_mask_i,
  input  logic [DATA_WIDTH-1:0]   m0_data_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_data_o,
  input  logic                    m1_req_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wr_mask_i,
  input  logic [DATA_WIDTH-1:0]   m1_data_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_data_o,
  output logic                    mem_sel_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH/8-1:0] mem_wr_mask_o,
  output logic [DATA_WIDTH-1:0]   mem_data_o,
  input  logic [DATA_WIDTH-1:0]   mem_data_i
);

  localparam int MW = DATA_WIDTH / 8;

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
    $error("MAX_BURST must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   rd_pend_q, rd_pend_d;
  logic   rd_tag_q, rd_tag_d;
  logic   g0, g1;
  logic   hold0, hold1;

`ifdef ARB_BURST_EN
  localparam logic [3:0] BMAX = 4'(MAX_BURST);
  logic [3:0] burst_cnt_q, burst_cnt_d;

  // Owner keeps ties until it has used its burst allowance
  always_comb begin
    hold0 = (state_q == OWN0) && (burst_cnt_q < BMAX);
    hold1 = (state_q == OWN1) && (burst_cnt_q < BMAX);
  end

  // Count consecutive grants to the same owner, restart on handover
  always_comb begin
    burst_cnt_d = 4'd0;
    if (g0) begin
      if (state_q == OWN0)
        burst_cnt_d = (burst_cnt_q == 4'hf) ? 4'hf : burst_cnt_q + 4'd1;
      else
        burst_cnt_d = 4'd1;
    end else if (g1) begin
      if (state_q == OWN1)
        burst_cnt_d = (burst_cnt_q == 4'hf) ? 4'hf : burst_cnt_q + 4'd1;
      else
        burst_cnt_d = 4'd1;
    end
  end

  // Burst counter register
  always_ff @(posedge clk) begin
    if (reset_i) burst_cnt_q <= 4'd0;
    else         burst_cnt_q <= burst_cnt_d;
  end
`else
  // Strict per-beat round-robin: no owner hold
  always_comb begin
    hold0 = 1'b0;
    hold1 = 1'b0;
  end
`endif

  // Grant decision; nothing is granted while reset is held
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset_i) begin
      if (m0_req_i && m1_req_i) begin
        if (hold0)       g0 = 1'b1;
        else if (hold1)  g1 = 1'b1;
        else if (last_q) g0 = 1'b1;
        else             g1 = 1'b1;
      end else begin
        g0 = m0_req_i;
        g1 = m1_req_i;
      end
    end
  end

  // Ownership and read-tracking next state
  always_comb begin
    state_d   = IDLE;
    last_d    = last_q;
    rd_pend_d = 1'b0;
    rd_tag_d  = rd_tag_q;
    if (g0) begin
      state_d   = OWN0;
      last_d    = 1'b0;
      rd_pend_d = ~m0_we_i;
      rd_tag_d  = 1'b0;
    end else if (g1) begin
      state_d   = OWN1;
      last_d    = 1'b1;
      rd_pend_d = ~m1_we_i;
      rd_tag_d  = 1'b1;
    end
  end

  // State registers; a read pending across reset is discarded
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

  // RAM port mux from the granted master, zero when idle
  always_comb begin
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wr_mask_o = '0;
    mem_data_o    = '0;
    if (g0) begin
      mem_we_o      = m0_we_i;
      mem_addr_o    = m0_addr_i;
      mem_wr_mask_o = m0_wr_mask_i;
      mem_data_o    = m0_data_i;
    end else if (g1) begin
      mem_we_o      = m1_we_i;
      mem_addr_o    = m1_addr_i;
      mem_wr_mask_o = m1_wr_mask_i;
      mem_data_o    = m1_data_i;
    end
  end

  assign m0_gnt_o  = g0;
  assign m1_gnt_o  = g1;
  assign mem_sel_o = g0 | g1;

  assign m0_rvalid_o = rd_pend_q & ~rd_tag_q & ~reset_i;
  assign m1_rvalid_o = rd_pend_q & rd_tag_q & ~reset_i;
  assign m0_data_o   = m0_rvalid_o ? mem_data_i : '0;
  assign m1_data_o   = m1_rvalid_o ? mem_data_i : '0;

  logic unused_mw;
  assign unused_mw = (MW == 0);

endmodule
